// File: rtl/bus_arb_pkg.sv
// Shared constants for the bus arbiter: active-low grant levels, policy encodings
// and a width helper used to size the owner index and tenure counter.
package bus_arb_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Never returns 0 so that one-state quantities still get a 1-bit vector.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational next-owner selector: round robin from start+1, or lowest index first.
// The request vector is active high and is expected to already exclude the current owner.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic [W-1:0] pick,
    output logic         found
);

    always_comb begin
        pick  = '0;
        found = 1'b0;
        if (mode == MODE_FIXED) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i]) begin
                    pick  = W'(i);
                    found = 1'b1;
                end
            end
        end else begin
            // Scan start+1, start+2, ... wrapping through index 0.
            for (int k = 1; k < N; k++) begin
                if (!found && req[(int'(start) + k) % N]) begin
                    pick  = W'((int'(start) + k) % N);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_param.sv
// Parameterised bus arbiter with round-robin / fixed-priority policy, tenure quantum,
// bus parking on the last owner and a one-cycle handover pulse after each switch.
module bus_arbiter_param
    import bus_arb_pkg::*;
#(
    parameter int  N_MASTERS = 4,
    parameter int  QUANTUM   = 16,
    localparam int OWNER_W   = clog2_min1(N_MASTERS),
    localparam int CNT_W     = clog2_min1(QUANTUM + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [N_MASTERS-1:0] req_,
    output logic [N_MASTERS-1:0] grnt_,
    output logic [OWNER_W-1:0]   owner,
    output logic                 handover
);

    localparam logic [CNT_W-1:0] CNT_MAX = (QUANTUM == 0) ? '0 : CNT_W'(QUANTUM - 1);

    logic [CNT_W-1:0]     cnt;
    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] others;
    logic [OWNER_W-1:0]   pick;
    logic                 found;
    logic                 owner_valid;
    logic                 owner_req;
    logic                 preempt;
    logic                 keep;

    assign req         = ~req_;
    assign owner_valid = int'(owner) < N_MASTERS;
    assign owner_req   = owner_valid && req[owner];
    assign preempt     = (QUANTUM != 0) && (cnt == CNT_MAX) && (|others);
    assign keep        = owner_req && !preempt;

    always_comb begin
        others = req;
        if (owner_valid) begin
            others[owner] = 1'b0;
        end
    end

    rr_pick #(
        .N (N_MASTERS),
        .W (OWNER_W)
    ) u_pick (
        .req   (others),
        .start (owner),
        .mode  (mode),
        .pick  (pick),
        .found (found)
    );

    // NOTE: state registers use non-blocking assignments and an asynchronous reset,
    // so reset forces the parked owner 0 grant without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= '0;
            cnt      <= '0;
            handover <= 1'b0;
        end else if (!owner_valid) begin
            owner    <= '0;
            cnt      <= '0;
            handover <= 1'b1;
        end else if (keep) begin
            if (QUANTUM != 0 && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            handover <= 1'b0;
        end else if (found) begin
            owner    <= pick;
            cnt      <= '0;
            handover <= 1'b1;
        end else begin
            // Released with nobody waiting: park on the same owner.
            cnt      <= '0;
            handover <= 1'b0;
        end
    end

    always_comb begin
        grnt_ = {N_MASTERS{DISABLE_}};
        if (owner_valid) begin
            grnt_[owner] = ENABLE_;
        end
    end

endmodule
